// File: rtl/conversor_binario_bcd_if.sv
// Request/result bundle between the product register, the BCD converter and the display.
// The master issues conversion requests; the slave returns the signed BCD code and status.
interface conversor_binario_bcd_if #(
  parameter int unsigned ANCHO   = 16,
  parameter int unsigned DIGITOS = 5
) ();

  logic                 inicio;
  logic [ANCHO-1:0]     binario;
  logic [4*DIGITOS:0]   codigo_BCD;
  logic                 ocupado;
  logic                 listo;

  modport master (
    output inicio,
    output binario,
    input  codigo_BCD,
    input  ocupado,
    input  listo
  );

  modport slave (
    input  inicio,
    input  binario,
    output codigo_BCD,
    output ocupado,
    output listo
  );

endinterface

// File: rtl/conversor_binario_bcd.sv
// Iterative signed-binary to BCD converter (double dabble), one shift per clock.
// Produces {sign, d(DIGITOS-1)..d0} for the 7-segment display block.
module conversor_binario_bcd #(
  parameter int unsigned ANCHO   = 16,
  parameter int unsigned DIGITOS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  conversor_binario_bcd_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITOS;
  localparam int unsigned CNT_W = $clog2(ANCHO + 1);

  typedef enum logic [0:0] {
    REPOSO   = 1'b0,
    DESPLAZA = 1'b1
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ANCHO-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               signo_q, signo_d;
  logic [BCD_W:0]     codigo_q, codigo_d;
  logic               ocupado_q, ocupado_d;
  logic               listo_q, listo_d;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_sh;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= REPOSO;
      cnt_q     <= '0;
      mag_q     <= '0;
      scratch_q <= '0;
      signo_q   <= 1'b0;
      codigo_q  <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      signo_q   <= signo_d;
      codigo_q  <= codigo_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
    end
  end

  // Next-state logic and one add-3/shift iteration
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    signo_d   = signo_q;
    codigo_d  = codigo_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;

    scratch_adj = scratch_q;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_sh = {scratch_adj[BCD_W-2:0], mag_q[ANCHO-1]};

    case (estado_q)
      REPOSO: begin
        if (bus.inicio) begin
          // Zero has no sign, so a negative zero can never be displayed
          signo_d   = bus.binario[ANCHO-1] & (|bus.binario);
          // Unsigned negation keeps 2^(ANCHO-1) exact for the most negative input
          mag_d     = bus.binario[ANCHO-1] ? (~bus.binario + ANCHO'(1)) : bus.binario;
          scratch_d = '0;
          cnt_d     = '0;
          ocupado_d = 1'b1;
          estado_d  = DESPLAZA;
        end
      end

      DESPLAZA: begin
        scratch_d = scratch_sh;
        mag_d     = {mag_q[ANCHO-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ANCHO - 1)) begin
          codigo_d  = {signo_q, scratch_sh};
          listo_d   = 1'b1;
          ocupado_d = 1'b0;
          estado_d  = REPOSO;
        end
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  assign bus.codigo_BCD = codigo_q;
  assign bus.ocupado    = ocupado_q;
  assign bus.listo      = listo_q;

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Bench for conversor_binario_bcd: directed vectors feed a scoreboard queue,
// a negedge monitor checks listo/ocupado/codigo_BCD every cycle against it.
module tb_conversor_binario_bcd;

  localparam int unsigned ANCHO   = 16;
  localparam int unsigned DIGITOS = 5;
  localparam time         PERIODO = 10;
  // Accepting edge to the negedge after the completion edge
  localparam time         LAT_T   = 16 * PERIODO + PERIODO / 2;

  typedef struct {
    logic [20:0] code;
    time         t0;
  } exp_t;

  logic clk;
  logic reset;

  conversor_binario_bcd_if #(.ANCHO(ANCHO), .DIGITOS(DIGITOS)) bus ();

  conversor_binario_bcd #(.ANCHO(ANCHO), .DIGITOS(DIGITOS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        q[$];
  logic [20:0] exp_code = '0;

  initial clk = 1'b0;
  always #(PERIODO / 2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sign plus decimal digits of |x|
  function automatic logic [20:0] bcd_ref(input logic [15:0] x);
    logic [20:0] r;
    int          m;
    m = int'($signed(x));
    r = '0;
    r[20] = (m < 0);
    if (m < 0) m = -m;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Monitor: listo exactly at the expected latency, ocupado while pending, code held otherwise
  always @(negedge clk) begin
    logic listo_exp;
    logic ocup_exp;
    listo_exp = 1'b0;
    if (q.size() > 0 && ($time - q[0].t0) == LAT_T) begin
      listo_exp = 1'b1;
      exp_code  = q[0].code;
    end
    ocup_exp = (q.size() > 0) && !listo_exp;
    chk("listo", 32'(bus.listo), 32'(listo_exp));
    chk("ocupado", 32'(bus.ocupado), 32'(ocup_exp));
    chk("codigo_BCD", 32'(bus.codigo_BCD), 32'(exp_code));
    if (q.size() > 0 && ($time - q[0].t0) >= LAT_T) void'(q.pop_front());
  end

  task automatic push_exp(input logic [20:0] e);
    exp_t it;
    it.code = e;
    it.t0   = $time;
    q.push_back(it);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic convert(input logic [15:0] v, input logic [20:0] e);
    @(negedge clk);
    bus.inicio  = 1'b1;
    bus.binario = v;
    @(posedge clk);
    push_exp(e);
    @(negedge clk);
    bus.inicio  = 1'b0;
    bus.binario = 16'($urandom);
    wait_done();
  endtask

  initial begin
    logic [15:0] v;
    reset       = 1'b0;
    bus.inicio  = 1'b0;
    bus.binario = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst codigo", 32'(bus.codigo_BCD), 32'd0);
    chk("rst ocupado", 32'(bus.ocupado), 32'd0);
    chk("rst listo", 32'(bus.listo), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    convert(16'd28, 21'h000028);
    convert(16'(-32768), 21'h132768);
    convert(16'd32767, 21'h032767);
    convert(16'(-16384), 21'h116384);
    convert(16'd0, 21'h000000);
    convert(16'(-1), 21'h100001);

    // Request while busy is dropped
    @(negedge clk);
    bus.inicio  = 1'b1;
    bus.binario = 16'd40;
    @(posedge clk);
    push_exp(21'h000040);
    @(negedge clk);
    bus.inicio  = 1'b0;
    bus.binario = 16'd99;
    repeat (4) @(negedge clk);
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);

    // inicio held high: accepts on E0 and E17
    @(negedge clk);
    bus.inicio  = 1'b1;
    bus.binario = 16'd1234;
    @(posedge clk);
    push_exp(21'h001234);
    @(negedge clk);
    bus.binario = 16'(-5678);
    repeat (17) @(posedge clk);
    push_exp(21'h105678);
    @(negedge clk);
    bus.inicio = 1'b0;
    wait_done();

    // Reset during iteration 8 discards the conversion
    @(negedge clk);
    bus.inicio  = 1'b1;
    bus.binario = 16'(-9999);
    @(posedge clk);
    push_exp(21'h109999);
    @(negedge clk);
    bus.inicio = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    exp_code = '0;
    #1;
    chk("async codigo", 32'(bus.codigo_BCD), 32'd0);
    chk("async ocupado", 32'(bus.ocupado), 32'd0);
    chk("async listo", 32'(bus.listo), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    convert(16'd7, 21'h000007);

    for (int n = 0; n < 1000; n++) begin
      v = 16'($urandom);
      convert(v, bcd_ref(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
